button_event_controller: RTL and testbench

//   Turns a vector of debounced switch levels into a stream of discrete button

---
 rtl/button_event_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_button_event_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_controller.sv
// Button event controller: turns debounced switch levels into PRESS / RELEASE /
// LONG / REPEAT events. Each channel has its own hold timer and a one-deep event
// slot. A round-robin arbiter shares a single valid/ready output between channels.
module button_event_controller #(
  parameter int unsigned WIDTH            = 4,
  parameter int unsigned LONG_PRESS_TICKS = 1000000,
  parameter int unsigned REPEAT_TICKS     = 200000,
  localparam int unsigned CW              = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CW-1:0]    evt_channel,
  output logic [1:0]       evt_type,
  output logic [WIDTH-1:0] overflow,
  input  logic             overflow_clr
);

  localparam int unsigned TMAX = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_PRESS_TICKS - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
  localparam bit REPEAT_ON = (REPEAT_TICKS != 0);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] rise, fall;

  state_t        state_q [WIDTH];
  state_t        state_d [WIDTH];
  logic [TW-1:0] timer_q [WIDTH];
  logic [TW-1:0] timer_d [WIDTH];

  logic [WIDTH-1:0]      gen;
  logic [WIDTH-1:0][1:0] kind;

  logic [WIDTH-1:0]      slot_full;
  logic [WIDTH-1:0][1:0] slot_type;
  logic [WIDTH-1:0]      granted;
  logic [WIDTH-1:0]      take;
  logic [WIDTH-1:0]      drop;

  logic [CW-1:0] ptr;
  logic [CW-1:0] pick_idx;
  logic          pick_any;
  logic          load_out;
  logic          grant;

  // Two-flop synchroniser plus previous-level register for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Per-channel state and hold-timer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // Next state and timer: a release beats a same-cycle timer expiry
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            state_d[i] = ST_PRESSED;
            timer_d[i] = '0;
          end
        end
        ST_PRESSED: begin
          if (fall[i]) begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
          end else if (timer_q[i] == LONG_LAST) begin
            state_d[i] = ST_HELD;
            timer_d[i] = '0;
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        ST_HELD: begin
          if (fall[i]) begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
          end else if (REPEAT_ON) begin
            if (timer_q[i] == REP_LAST) timer_d[i] = '0;
            else                        timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  // Event generation decoded from the current state, edges and timer
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      gen[i]  = 1'b0;
      kind[i] = EV_PRESS;
      case (state_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            gen[i]  = 1'b1;
            kind[i] = EV_PRESS;
          end
        end
        ST_PRESSED: begin
          if (fall[i]) begin
            gen[i]  = 1'b1;
            kind[i] = EV_RELEASE;
          end else if (timer_q[i] == LONG_LAST) begin
            gen[i]  = 1'b1;
            kind[i] = EV_LONG;
          end
        end
        ST_HELD: begin
          if (fall[i]) begin
            gen[i]  = 1'b1;
            kind[i] = EV_RELEASE;
          end else if (REPEAT_ON && (timer_q[i] == REP_LAST)) begin
            gen[i]  = 1'b1;
            kind[i] = EV_REPEAT;
          end
        end
        default: begin
          gen[i]  = 1'b0;
          kind[i] = EV_PRESS;
        end
      endcase
    end
  end

  // Round-robin search over full slots starting at the pointer
  always_comb begin
    int unsigned idx;
    pick_any = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!pick_any && slot_full[CW'(idx)]) begin
        pick_any = 1'b1;
        pick_idx = CW'(idx);
      end
    end
  end

  assign load_out = ~evt_valid | evt_ready;
  assign grant    = pick_any & load_out;

  // Slot bookkeeping: a granted slot can accept a new event in the same cycle
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      granted[i] = grant && (pick_idx == CW'(i));
      take[i]    = gen[i] && (!slot_full[i] || granted[i]);
      drop[i]    = gen[i] && slot_full[i] && !granted[i];
    end
  end

  // Event slots and sticky overflow flags (a new drop beats a clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_full <= '0;
      slot_type <= '0;
      overflow  <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (take[i]) begin
          slot_full[i] <= 1'b1;
          slot_type[i] <= kind[i];
        end else if (granted[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
      overflow <= (overflow & ~{WIDTH{overflow_clr}}) | drop;
    end
  end

  // Output register and arbiter pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid   <= 1'b0;
      evt_channel <= '0;
      evt_type    <= '0;
      ptr         <= '0;
    end else begin
      if (load_out) begin
        evt_valid <= pick_any;
        if (pick_any) begin
          evt_channel <= pick_idx;
          evt_type    <= slot_type[pick_idx];
        end
      end
      if (grant) begin
        ptr <= (pick_idx == CW'(WIDTH - 1)) ? '0 : pick_idx + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_event_controller.sv
// Self-checking bench for button_event_controller (WIDTH=4, LONG=8, REPEAT=4,
// plus a second instance with repeat disabled fed the same inputs).
module tb_button_event_controller;

  localparam int W = 4;
  localparam int L = 8;
  localparam int R = 4;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] in_sig;
  logic         ready;
  logic         clr;
  logic         evt_valid;
  logic [1:0]   evt_channel;
  logic [1:0]   evt_type;
  logic [W-1:0] overflow;
  logic         v0;
  logic [1:0]   ch0;
  logic [1:0]   ty0;
  logic [W-1:0] ovf0;

  int n_pass;
  int n_check;
  bit rec;

  logic [W-1:0] hist[$];
  int obs_ch[$];
  int obs_type[$];
  int obs_t[$];
  int obs0_type[$];
  int exp_type[$];
  int exp_t[$];

  button_event_controller #(.WIDTH(W), .LONG_PRESS_TICKS(L), .REPEAT_TICKS(R)) dut (
    .clk(clk), .reset_n(reset_n), .in(in_sig), .evt_valid(evt_valid), .evt_ready(ready),
    .evt_channel(evt_channel), .evt_type(evt_type), .overflow(overflow), .overflow_clr(clr)
  );

  button_event_controller #(.WIDTH(W), .LONG_PRESS_TICKS(L), .REPEAT_TICKS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in(in_sig), .evt_valid(v0), .evt_ready(1'b1),
    .evt_channel(ch0), .evt_type(ty0), .overflow(ovf0), .overflow_clr(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record input samples and accepted events between clock edges
  always @(negedge clk) begin
    if (rec) begin
      hist.push_back(in_sig);
      if (evt_valid && ready) begin
        obs_ch.push_back(int'(evt_channel));
        obs_type.push_back(int'(evt_type));
        obs_t.push_back(hist.size() - 1);
      end
      if (v0) obs0_type.push_back(int'(ty0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rec = 1'b0; in_sig = '0; ready = 1'b1; clr = 1'b0; reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic start_rec();
    hist.delete(); obs_ch.delete(); obs_type.delete(); obs_t.delete(); obs0_type.delete();
    rec = 1'b1;
  endtask

  task automatic add_timed(input int start, input int stop, input int r);
    int t;
    t = start + L;
    if (t < stop) begin
      exp_type.push_back(2); exp_t.push_back(t);
      if (r != 0) begin
        for (t = t + r; t < stop; t += r) begin
          exp_type.push_back(3); exp_t.push_back(t);
        end
      end
    end
  endtask

  // Reference: events of channel c derived from press/release runs in the sample history
  task automatic model(input int c, input int r);
    int prev, start, lvl;
    exp_type.delete(); exp_t.delete();
    prev = 0; start = 0;
    for (int n = 0; n < hist.size(); n++) begin
      lvl = int'(hist[n][c]);
      if (lvl == 1 && prev == 0) begin
        exp_type.push_back(0); exp_t.push_back(n); start = n;
      end else if (lvl == 0 && prev == 1) begin
        add_timed(start, n, r);
        exp_type.push_back(1); exp_t.push_back(n);
      end
      prev = lvl;
    end
    if (prev == 1) add_timed(start, hist.size(), r);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_sig = '0; ready = 1'b1; clr = 1'b0; rec = 1'b0;
    repeat (2) step();
    n_check++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", evt_valid); else n_pass++;
    n_check++; if (evt_channel !== 2'd0) $display("FAIL reset_channel got=%0d want=0", evt_channel); else n_pass++;
    n_check++; if (evt_type !== 2'd0) $display("FAIL reset_type got=%0d want=0", evt_type); else n_pass++;
    n_check++; if (overflow !== 4'h0) $display("FAIL reset_overflow got=%h want=0", overflow); else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_press_release();
    int a;
    apply_reset(); start_rec();
    step();
    in_sig[1] = 1'b1; a = hist.size();
    repeat (3) step();
    in_sig[1] = 1'b0;
    repeat (20) step();
    rec = 1'b0;
    n_check++; if (obs_ch.size() !== 2) $display("FAIL pr_count got=%0d want=2", obs_ch.size()); else n_pass++;
    if (obs_ch.size() == 2) begin
      n_check++; if (obs_ch[0] !== 1 || obs_type[0] !== 0) $display("FAIL pr_press got=ch%0d/t%0d want=ch1/t0", obs_ch[0], obs_type[0]); else n_pass++;
      n_check++; if (obs_t[0] !== a + 4) $display("FAIL pr_latency got=%0d want=%0d", obs_t[0], a + 4); else n_pass++;
      n_check++; if (obs_ch[1] !== 1 || obs_type[1] !== 1) $display("FAIL pr_release got=ch%0d/t%0d want=ch1/t1", obs_ch[1], obs_type[1]); else n_pass++;
      n_check++; if (obs_t[1] !== a + 7) $display("FAIL pr_rel_time got=%0d want=%0d", obs_t[1], a + 7); else n_pass++;
    end
  endtask

  task automatic test_long_repeat();
    int nrep;
    apply_reset(); start_rec();
    step();
    in_sig[3] = 1'b1;
    repeat (30) step();
    in_sig[3] = 1'b0;
    repeat (20) step();
    rec = 1'b0;
    model(3, R);
    n_check++; if (obs_ch.size() !== exp_type.size()) $display("FAIL lr_count got=%0d want=%0d", obs_ch.size(), exp_type.size()); else n_pass++;
    if (obs_ch.size() == exp_type.size()) begin
      for (int j = 0; j < obs_ch.size(); j++) begin
        n_check++;
        if (obs_ch[j] !== 3 || obs_type[j] !== exp_type[j] || obs_t[j] !== exp_t[j] + 4)
          $display("FAIL lr_event%0d got=ch%0d/t%0d@%0d want=ch3/t%0d@%0d", j, obs_ch[j], obs_type[j], obs_t[j], exp_type[j], exp_t[j] + 4);
        else n_pass++;
      end
    end
    nrep = 0;
    foreach (obs_type[j]) if (obs_type[j] == 3) nrep++;
    n_check++; if (nrep !== 5) $display("FAIL lr_repeats got=%0d want=5", nrep); else n_pass++;
    model(3, 0);
    n_check++; if (obs0_type.size() !== exp_type.size()) $display("FAIL norep_count got=%0d want=%0d", obs0_type.size(), exp_type.size()); else n_pass++;
    if (obs0_type.size() == exp_type.size()) begin
      for (int j = 0; j < obs0_type.size(); j++) begin
        n_check++; if (obs0_type[j] !== exp_type[j]) $display("FAIL norep_event%0d got=%0d want=%0d", j, obs0_type[j], exp_type[j]); else n_pass++;
      end
    end
    nrep = 0;
    foreach (obs0_type[j]) if (obs0_type[j] == 3) nrep++;
    n_check++; if (nrep !== 0) $display("FAIL norep_repeats got=%0d want=0", nrep); else n_pass++;
  endtask

  task automatic test_arbitration();
    apply_reset(); start_rec();
    step();
    in_sig = 4'b0101; repeat (6) step();
    in_sig = 4'b0000; repeat (6) step();
    in_sig = 4'b0001; repeat (6) step();
    in_sig = 4'b0100; repeat (6) step();
    in_sig = 4'b0000; repeat (8) step();
    rec = 1'b0;
    n_check++; if (obs_ch.size() !== 8) $display("FAIL arb_count got=%0d want=8", obs_ch.size()); else n_pass++;
    if (obs_ch.size() == 8) begin
      n_check++; if (obs_ch[0] !== 0 || obs_ch[1] !== 2) $display("FAIL arb_order_ptr0 got=%0d,%0d want=0,2", obs_ch[0], obs_ch[1]); else n_pass++;
      n_check++; if (obs_t[1] !== obs_t[0] + 1) $display("FAIL arb_b2b_ptr0 got=%0d want=%0d", obs_t[1], obs_t[0] + 1); else n_pass++;
      n_check++; if (obs_ch[2] !== 0 || obs_ch[3] !== 2) $display("FAIL arb_order_ptr3 got=%0d,%0d want=0,2", obs_ch[2], obs_ch[3]); else n_pass++;
      n_check++; if (obs_ch[5] !== 2 || obs_type[5] !== 0) $display("FAIL arb_ptr1_first got=ch%0d/t%0d want=ch2/t0", obs_ch[5], obs_type[5]); else n_pass++;
      n_check++; if (obs_ch[6] !== 0 || obs_type[6] !== 1) $display("FAIL arb_ptr1_second got=ch%0d/t%0d want=ch0/t1", obs_ch[6], obs_type[6]); else n_pass++;
      n_check++; if (obs_t[6] !== obs_t[5] + 1) $display("FAIL arb_b2b_ptr1 got=%0d want=%0d", obs_t[6], obs_t[5] + 1); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    apply_reset(); start_rec();
    ready = 1'b0;
    in_sig[1] = 1'b1; repeat (4) step();
    in_sig[1] = 1'b0; repeat (4) step();
    in_sig[1] = 1'b1; repeat (4) step();
    in_sig[1] = 1'b0; repeat (6) step();
    n_check++; if (evt_valid !== 1'b1) $display("FAIL ovf_valid got=%0b want=1", evt_valid); else n_pass++;
    n_check++; if (evt_channel !== 2'd1 || evt_type !== 2'd0) $display("FAIL ovf_hold got=ch%0d/t%0d want=ch1/t0", evt_channel, evt_type); else n_pass++;
    n_check++; if (overflow !== 4'b0010) $display("FAIL ovf_set got=%b want=0010", overflow); else n_pass++;
    repeat (3) step();
    n_check++; if (evt_channel !== 2'd1 || evt_type !== 2'd0) $display("FAIL ovf_stable got=ch%0d/t%0d want=ch1/t0", evt_channel, evt_type); else n_pass++;
    clr = 1'b1; step(); clr = 1'b0;
    n_check++; if (overflow !== 4'b0000) $display("FAIL ovf_clear got=%b want=0000", overflow); else n_pass++;
    in_sig[1] = 1'b1; step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    n_check++; if (overflow !== 4'b0010) $display("FAIL ovf_set_wins got=%b want=0010", overflow); else n_pass++;
    repeat (2) step();
    in_sig[1] = 1'b0; repeat (4) step();
    ready = 1'b1; repeat (8) step();
    rec = 1'b0;
    n_check++; if (obs_ch.size() !== 2) $display("FAIL ovf_drain_count got=%0d want=2", obs_ch.size()); else n_pass++;
    if (obs_ch.size() == 2) begin
      n_check++; if (obs_ch[0] !== 1 || obs_type[0] !== 0 || obs_ch[1] !== 1 || obs_type[1] !== 1)
        $display("FAIL ovf_drain got=ch%0d/t%0d,ch%0d/t%0d want=ch1/t0,ch1/t1", obs_ch[0], obs_type[0], obs_ch[1], obs_type[1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ready = 1'b0;
    in_sig[2] = 1'b1; repeat (20) step();
    n_check++; if (evt_valid !== 1'b1 || overflow !== 4'b0100) $display("FAIL mid_pre got=v%0b/o%b want=v1/o0100", evt_valid, overflow); else n_pass++;
    reset_n = 1'b0; #1;
    n_check++; if (evt_valid !== 1'b0) $display("FAIL mid_valid got=%0b want=0", evt_valid); else n_pass++;
    n_check++; if (overflow !== 4'b0000) $display("FAIL mid_overflow got=%b want=0000", overflow); else n_pass++;
    n_check++; if (evt_channel !== 2'd0 || evt_type !== 2'd0) $display("FAIL mid_fields got=ch%0d/t%0d want=0/0", evt_channel, evt_type); else n_pass++;
    ready = 1'b1; start_rec();
    step(); step();
    reset_n = 1'b1;
    repeat (8) step();
    rec = 1'b0;
    n_check++; if (obs_ch.size() !== 1) $display("FAIL mid_count got=%0d want=1", obs_ch.size()); else n_pass++;
    if (obs_ch.size() >= 1) begin
      n_check++; if (obs_ch[0] !== 2 || obs_type[0] !== 0) $display("FAIL mid_press got=ch%0d/t%0d want=ch2/t0", obs_ch[0], obs_type[0]); else n_pass++;
    end
    in_sig = '0; repeat (10) step();
  endtask

  task automatic test_random();
    for (int ph = 0; ph < 2; ph++) begin
      apply_reset(); start_rec();
      if (ph == 0) begin
        for (int i = 0; i < 200; i++) begin
          in_sig = ~in_sig; ready = ($urandom_range(1) == 1); step();
        end
        ready = 1'b1; repeat (20) step();
      end else begin
        for (int i = 0; i < 600; i++) begin
          for (int c = 0; c < W; c++) if ($urandom_range(15) == 0) in_sig[c] = ~in_sig[c];
          ready = ($urandom_range(3) != 0); step();
        end
        in_sig = '0; ready = 1'b1; repeat (40) step();
      end
      rec = 1'b0;
      if (ph == 0) begin
        n_check++; if (overflow !== 4'hF) $display("FAIL storm_overflow got=%h want=f", overflow); else n_pass++;
        for (int j = 1; j < obs_ch.size(); j++) begin
          n_check++;
          if (obs_ch[j] !== (obs_ch[j-1] + 1) % W) $display("FAIL storm_rr%0d got=%0d want=%0d", j, obs_ch[j], (obs_ch[j-1] + 1) % W);
          else n_pass++;
        end
      end
      for (int c = 0; c < W; c++) begin
        int k;
        int n_obs;
        bit ok;
        model(c, R);
        k = 0; n_obs = 0; ok = 1'b1;
        for (int j = 0; j < obs_ch.size(); j++) begin
          if (obs_ch[j] == c) begin
            n_obs++;
            while (k < exp_type.size() && exp_type[k] != obs_type[j]) k++;
            if (k >= exp_type.size()) ok = 1'b0;
            else k++;
          end
        end
        n_check++; if (!ok) $display("FAIL rand%0d_order ch%0d observed events not in reference order", ph, c); else n_pass++;
        n_check++;
        if (overflow[c]) begin
          if (n_obs >= exp_type.size()) $display("FAIL rand%0d_lost ch%0d got=%0d want<%0d", ph, c, n_obs, exp_type.size());
          else n_pass++;
        end else begin
          if (n_obs != exp_type.size()) $display("FAIL rand%0d_count ch%0d got=%0d want=%0d", ph, c, n_obs, exp_type.size());
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    n_pass = 0; n_check = 0; rec = 1'b0;
    in_sig = '0; ready = 1'b1; clr = 1'b0; reset_n = 1'b0;
    test_reset();
    test_press_release();
    test_long_repeat();
    test_arbitration();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
